slave_split_ctrl: RTL and testbench

// Slave-side split-transaction sequencer; one per slave port, paired with one bus_controller

---
 rtl/slave_split_ctrl_if.sv | 29 ++
 rtl/slave_split_ctrl.sv | 164 ++++++++++++++++
 tb/tb_slave_split_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/slave_split_ctrl_if.sv
// Handshake bundle between a slave interface and its split-transaction
// sequencer. The split wire itself stays a plain inout on the sequencer,
// because it is a shared, pulled-up net rather than a point-to-point signal.
interface slave_split_ctrl_if #(
  parameter int LAT_W = 8
);
  logic             txn_start;
  logic [LAT_W-1:0] mem_latency;
  logic             mem_start;
  logic             mem_done;
  logic             resp_ready;
  logic             resp_sent;
  logic             txn_busy;
  logic             split_active;
  logic             timeout_err;
  logic [2:0]       state;

  // Sequencer side
  modport slave (
    input  txn_start, mem_latency, mem_done, resp_sent,
    output mem_start, resp_ready, txn_busy, split_active, timeout_err, state
  );

  // Slave-interface / environment side
  modport master (
    output txn_start, mem_latency, mem_done, resp_sent,
    input  mem_start, resp_ready, txn_busy, split_active, timeout_err, state
  );
endinterface

// File: rtl/slave_split_ctrl.sv
// Slave-side split-transaction sequencer. Long accesses pull the split wire
// low while memory works, pulse it high once on completion, then wait for the
// arbiter's one-cycle low ack before presenting the response. Short accesses
// go straight to the response without splitting.
module slave_split_ctrl #(
  parameter int LAT_W        = 8,
  parameter int SPLIT_THRESH = 4,
  parameter int MIN_BUSY     = 4,
  parameter int ACK_TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rstn,
  inout  wire               split_line,
  slave_split_ctrl_if.slave bus
);

  localparam int CNT_SRC = (MIN_BUSY > ACK_TIMEOUT) ? MIN_BUSY : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_SRC) + 1;

  localparam logic [CNT_W-1:0] BUSY_EXIT = CNT_W'(MIN_BUSY - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DIRECT     = 3'd1,
    ST_SPLIT_BUSY = 3'd2,
    ST_RELEASE    = 3'd3,
    ST_WAIT_ACK   = 3'd4,
    ST_RESPOND    = 3'd5
  } state_e;

  // Outputs that are a pure function of the state being entered
  typedef struct packed {
    logic txn_busy;
    logic split_active;
    logic resp_ready;
    logic line_oe;
    logic line_val;
  } outs_t;

  localparam outs_t OUTS_IDLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic outs_t outs_for(input state_e s);
    outs_t o;
    o = OUTS_IDLE;
    case (s)
      ST_IDLE:       o = OUTS_IDLE;
      ST_DIRECT:     o = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      ST_SPLIT_BUSY: o = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      ST_RELEASE:    o = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      ST_WAIT_ACK:   o = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      ST_RESPOND:    o = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      default:       o = OUTS_IDLE;
    endcase
    return o;
  endfunction

  state_e           r_state;
  outs_t            r_out;
  logic             r_mem_start;
  logic             r_timeout_err;
  logic             r_done;
  logic [CNT_W-1:0] r_busy_cnt;
  logic [CNT_W-1:0] r_ack_cnt;

  logic w_line_in;
  logic w_long;
  logic w_done_any;

  // The wire is only ever driven from registers; Z otherwise (arbiter pull-up)
  assign split_line = r_out.line_oe ? r_out.line_val : 1'bz;
  assign w_line_in  = split_line;
  assign w_long     = bus.mem_latency > LAT_W'(SPLIT_THRESH);
  assign w_done_any = r_done | bus.mem_done;

  assign bus.state        = r_state;
  assign bus.mem_start    = r_mem_start;
  assign bus.resp_ready   = r_out.resp_ready;
  assign bus.txn_busy     = r_out.txn_busy;
  assign bus.split_active = r_out.split_active;
  assign bus.timeout_err  = r_timeout_err;

  // Sequencer FSM: state, counters, done flag and all registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_out         <= OUTS_IDLE;
      r_mem_start   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_done        <= 1'b0;
      r_busy_cnt    <= CNT_ZERO;
      r_ack_cnt     <= CNT_ZERO;
    end else begin
      r_mem_start   <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.txn_start) begin
            r_mem_start <= 1'b1;
            if (w_long) begin
              r_state    <= ST_SPLIT_BUSY;
              r_out      <= outs_for(ST_SPLIT_BUSY);
              r_busy_cnt <= CNT_ZERO;
              r_done     <= 1'b0;
            end else begin
              r_state <= ST_DIRECT;
              r_out   <= outs_for(ST_DIRECT);
            end
          end
        end
        ST_DIRECT: begin
          if (bus.mem_done) begin
            r_state <= ST_RESPOND;
            r_out   <= outs_for(ST_RESPOND);
          end
        end
        ST_SPLIT_BUSY: begin
          // A done arriving this cycle counts immediately so release is not delayed
          if (w_done_any && (r_busy_cnt >= BUSY_EXIT)) begin
            r_state <= ST_RELEASE;
            r_out   <= outs_for(ST_RELEASE);
            r_done  <= 1'b0;
          end else begin
            r_done <= w_done_any;
            if (r_busy_cnt != CNT_SAT) begin
              r_busy_cnt <= r_busy_cnt + CNT_ONE;
            end
          end
        end
        ST_RELEASE: begin
          r_state   <= ST_WAIT_ACK;
          r_out     <= outs_for(ST_WAIT_ACK);
          r_ack_cnt <= CNT_ZERO;
        end
        ST_WAIT_ACK: begin
          if (w_line_in == 1'b0) begin
            r_state <= ST_RESPOND;
            r_out   <= outs_for(ST_RESPOND);
          end else if (r_ack_cnt == ACK_LAST) begin
            r_state       <= ST_IDLE;
            r_out         <= outs_for(ST_IDLE);
            r_timeout_err <= 1'b1;
          end else begin
            r_ack_cnt <= r_ack_cnt + CNT_ONE;
          end
        end
        ST_RESPOND: begin
          if (bus.resp_sent) begin
            r_state <= ST_IDLE;
            r_out   <= outs_for(ST_IDLE);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_out   <= OUTS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_split_ctrl.sv
// Directed bench for slave_split_ctrl: a per-cycle vector table followed by
// hand-written sequences for split timing, ack timeout, reset during a split
// and an arbiter-style re-grant.
module tb_slave_split_ctrl;

  logic clk = 1'b0;
  logic rstn;
  logic r_ack_low;
  tri1  w_split_line;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign w_split_line = r_ack_low ? 1'b0 : 1'bz;

  slave_split_ctrl_if #(.LAT_W(8)) bus_if ();

  slave_split_ctrl #(
    .LAT_W(8), .SPLIT_THRESH(4), .MIN_BUSY(4), .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk), .rstn(rstn), .split_line(w_split_line), .bus(bus_if)
  );

  typedef struct {
    logic       ts;
    logic [7:0] lat;
    logic       md;
    logic       rs;
    logic       ack;
    logic [8:0] exp;   // {state, mem_start, resp_ready, line, busy, split_active, timeout_err}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ts, logic [7:0] lat, logic md, logic rs, logic ack,
                              logic [2:0] st, logic ms, logic rr, logic ln,
                              logic bz, logic sa, logic te);
    vec_t v;
    v.ts = ts; v.lat = lat; v.md = md; v.rs = rs; v.ack = ack;
    v.exp = {st, ms, rr, ln, bz, sa, te};
    return v;
  endfunction

  function automatic logic [8:0] outs_now();
    return {bus_if.state, bus_if.mem_start, bus_if.resp_ready, w_split_line,
            bus_if.txn_busy, bus_if.split_active, bus_if.timeout_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ts, input logic [7:0] lat, input logic md,
                       input logic rs, input logic ack);
    bus_if.txn_start   = ts;
    bus_if.mem_latency = lat;
    bus_if.mem_done    = md;
    bus_if.resp_sent   = rs;
    r_ack_low          = ack;
  endtask

  // One clock: inputs are sampled, pulses are withdrawn, outputs settle for checking
  task automatic step();
    @(posedge clk);
    #1;
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int exp_st;
    logic seen4;
    logic seen_low;
    int rel_cyc;
    int rr_rises;
    int rr_high;
    int ms_extra;
    logic prev_rr;
    logic rs_done;
    logic finished;

    rstn = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", 32'(outs_now()), 32'(9'b000_0_0_1_0_0_0));
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("post_reset_idle", 32'(outs_now()), 32'(9'b000_0_0_1_0_0_0));

    // ts lat md rs ack | st ms rr line busy sa te
    // direct access, two idle cycles before done
    vecs.push_back(mk(1, 8'd2,   0, 0, 0, 3'd1, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0,   0, 0, 0, 3'd1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0,   0, 0, 0, 3'd1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0,   1, 0, 0, 3'd5, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0,   0, 0, 0, 3'd5, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0,   0, 1, 0, 3'd0, 0, 0, 1, 0, 0, 0));
    // latency equal to threshold stays direct; done in entry cycle; txn_start in RESPOND ignored
    vecs.push_back(mk(1, 8'd4,   0, 0, 0, 3'd1, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0,   1, 0, 0, 3'd5, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 8'd9,   0, 0, 0, 3'd5, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 8'd9,   0, 1, 0, 3'd0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'd0,   1, 1, 0, 3'd0, 0, 0, 1, 0, 0, 0));
    // latency one above threshold splits; early done holds line low exactly 4 cycles
    vecs.push_back(mk(1, 8'd5,   0, 0, 0, 3'd2, 1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'd0,   1, 0, 0, 3'd2, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'd0,   0, 0, 0, 3'd2, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'd0,   0, 0, 0, 3'd2, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'd0,   0, 0, 0, 3'd3, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 8'd0,   0, 0, 0, 3'd4, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 8'd0,   1, 0, 0, 3'd4, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 8'd0,   0, 0, 1, 3'd5, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0,   0, 1, 0, 3'd0, 0, 0, 1, 0, 0, 0));
    // max latency; low sample while busy is not an ack; done at busy_cnt=1
    vecs.push_back(mk(1, 8'd255, 0, 0, 0, 3'd2, 1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'd0,   0, 0, 1, 3'd2, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'd0,   1, 0, 0, 3'd2, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'd0,   0, 0, 0, 3'd2, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'd0,   0, 0, 0, 3'd3, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 8'd0,   0, 0, 0, 3'd4, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 8'd0,   0, 0, 1, 3'd5, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0,   0, 1, 0, 3'd0, 0, 0, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].ts, vecs[i].lat, vecs[i].md, vecs[i].rs, vecs[i].ack);
      step();
      chk($sformatf("vec%0d", i), 32'(outs_now()), 32'(vecs[i].exp));
    end

    // Long split: txn at 0, done at 25, ack at 30
    for (int k = 0; k < 31; k++) begin
      drive(k == 0, 8'd20, k == 25, 1'b0, k == 30);
      step();
      exp_st = (k + 1 <= 25) ? 2 : (k + 1 == 26) ? 3 : (k + 1 <= 30) ? 4 : 5;
      chk($sformatf("split_state_c%0d", k + 1), 32'(bus_if.state), 32'(exp_st));
      chk($sformatf("split_line_c%0d", k + 1), 32'(w_split_line), 32'((k + 1 <= 25) ? 0 : 1));
    end
    chk("split_resp_ready", 32'(bus_if.resp_ready), 32'd1);
    drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    step();
    chk("split_back_idle", 32'(bus_if.state), 32'd0);

    // Ack timeout: no ack ever arrives
    drive(1'b1, 8'd6, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    step();
    cnt = 0;
    seen4 = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus_if.state == 3'd4) begin
        seen4 = 1'b1;
        cnt++;
      end else if (seen4) begin
        break;
      end
      step();
    end
    chk("timeout_wait_cycles", 32'(cnt), 32'd16);
    chk("timeout_exit", 32'(outs_now()), 32'(9'b000_0_0_1_0_0_1));
    step();
    chk("timeout_err_pulse", 32'(bus_if.timeout_err), 32'd0);

    // Reset asserted mid-split releases the line in the same cycle
    drive(1'b1, 8'd30, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_pre_state", 32'(bus_if.state), 32'd2);
    chk("rst_pre_line", 32'(w_split_line), 32'd0);
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_mid_split", 32'(outs_now()), 32'(9'b000_0_0_1_0_0_0));
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("rst_after_idle", 32'(outs_now()), 32'(9'b000_0_0_1_0_0_0));

    // Arbiter-style re-grant: other master served while split, then ack
    seen_low = 1'b0;
    rel_cyc  = -1;
    rr_rises = 0;
    rr_high  = 0;
    ms_extra = 0;
    prev_rr  = 1'b0;
    rs_done  = 1'b0;
    finished = 1'b0;
    for (int k = 0; k < 100; k++) begin
      drive(k == 0, 8'd10, k == 8, (rr_high >= 2) && !rs_done,
            (rel_cyc >= 0) && (k == rel_cyc + 3));
      if ((rr_high >= 2) && !rs_done) rs_done = 1'b1;
      if (k == 3) bus_if.txn_start = 1'b1;
      step();
      if (w_split_line == 1'b0 && rel_cyc < 0) seen_low = 1'b1;
      else if (seen_low && rel_cyc < 0) rel_cyc = k + 1;
      if (k >= 1 && bus_if.mem_start) ms_extra++;
      if (bus_if.resp_ready && !prev_rr) rr_rises++;
      if (bus_if.resp_ready) rr_high++;
      prev_rr = bus_if.resp_ready;
      if (rs_done && bus_if.state == 3'd0) begin
        finished = 1'b1;
        break;
      end
    end
    chk("regrant_finished", 32'(finished), 32'd1);
    chk("regrant_rr_once", 32'(rr_rises), 32'd1);
    chk("regrant_no_extra_mem_start", 32'(ms_extra), 32'd0);
    chk("regrant_idle", 32'(outs_now()), 32'(9'b000_0_0_1_0_0_0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
